// File: rtl/serial_carry_sequencer_if.sv
// Operand/result handshake bundle for serial_carry_sequencer.
//   slave  modport : the sequencer (accepts operands, presents results)
//   master modport : the operand producer / result consumer
// Signals:
//   in_valid / in_ready            operand handshake
//   op_a, op_b (WIDTH), op_cin     operands and carry-in
//   out_valid / out_ready          result handshake
//   sum (WIDTH), cout, overflow    result
interface serial_carry_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/serial_carry_sequencer.sv
// Bit-serial adder controller wrapped around a single fabric carry cell.
// Operands are accepted in IDLE, then one bit per cycle is presented to the
// cell (P, G, CIN); the cell's SUMOUT is captured into the result and its
// COUT is fed back as the next CIN. After WIDTH bits the result (sum, cout,
// signed overflow) is offered until the consumer accepts it.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   bus (slave modport)        operand / result valid-ready handshakes
//   adder_carry_p/g/cin        drive to the carry cell (0 outside RUN)
//   adder_carry_sumout/cout    combinational response from the carry cell
module serial_carry_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  serial_carry_sequencer_if.slave     bus,
  output logic                        adder_carry_p,
  output logic                        adder_carry_g,
  output logic                        adder_carry_cin,
  input  logic                        adder_carry_sumout,
  input  logic                        adder_carry_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic             running;
  logic             last_bit;
  logic [WIDTH-1:0] sum_bit_we;

  assign running  = (state_reg == S_RUN);
  assign last_bit = (idx_reg == LAST_IDX);

  // One-hot write enable for the sum bit currently being produced; the
  // other bits keep their previous contents.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum_we
      assign sum_bit_we[gi] = running && (idx_reg == IW'(gi));
    end
  endgenerate

  // Cell drive comes straight from registered state so the cell sees a
  // stable P/G/CIN for the whole RUN cycle and its response settles before
  // the capturing edge.
  assign adder_carry_p   = running & (a_reg[idx_reg] ^ b_reg[idx_reg]);
  assign adder_carry_g   = running & (a_reg[idx_reg] & b_reg[idx_reg]);
  assign adder_carry_cin = running & carry_reg;

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = overflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sum_bit_we[i]) begin
          sum_reg[i] <= adder_carry_sumout;
        end
      end

      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.op_a;
            b_reg        <= bus.op_b;
            carry_reg    <= bus.op_cin;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= S_RUN;
          end
        end

        S_RUN: begin
          carry_reg <= adder_carry_cout;
          if (last_bit) begin
            // carry_reg still holds the carry into the MSB here.
            cout_reg      <= adder_carry_cout;
            overflow_reg  <= carry_reg ^ adder_carry_cout;
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end

        default: begin
          state_reg     <= S_IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_carry_sequencer.sv
// Self-checking bench for serial_carry_sequencer (WIDTH=8). The carry cell is
// modelled from its contract; expected results come from plain integer
// arithmetic on the operands.
module tb_serial_carry_sequencer;

  localparam int W = 8;

  logic clk;
  logic reset;
  logic cell_p, cell_g, cell_cin, cell_sumout, cell_cout;

  int checks;
  int errors;

  serial_carry_sequencer_if #(.WIDTH(W)) bus ();

  serial_carry_sequencer #(.WIDTH(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .adder_carry_p      (cell_p),
    .adder_carry_g      (cell_g),
    .adder_carry_cin    (cell_cin),
    .adder_carry_sumout (cell_sumout),
    .adder_carry_cout   (cell_cout)
  );

  // Carry cell contract.
  assign cell_sumout = cell_p ^ cell_cin;
  assign cell_cout   = cell_p ? cell_cin : cell_g;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_sum(int a, int b, int c);
    return W'((a + b + c) % 256);
  endfunction

  function automatic logic ref_cout(int a, int b, int c);
    return (a + b + c) >= 256;
  endfunction

  function automatic logic ref_ovf(int a, int b, int c);
    int sa, sb, s;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    s  = sa + sb + c;
    return (s > 127) || (s < -128);
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands and returns after the accepting edge (+1).
  task automatic accept(input int a, input int b, input int c, output bit ok);
    ok = 1'b0;
    bus.op_a     = W'(a);
    bus.op_b     = W'(b);
    bus.op_cin   = c[0];
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (bus.in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Edges waited until out_valid is seen, or -1 on timeout.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!bus.out_valid) n = -1;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.sum !== 8'h00 || bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: sum=%h cout=%b ovf=%b required 00/0/0", bus.sum, bus.cout, bus.overflow);
    end
    checks++;
    if ({cell_p, cell_g, cell_cin} !== 3'b000) begin
      errors++;
      $display("FAIL reset_cell: pgc=%b required 000", {cell_p, cell_g, cell_cin});
    end
    $display("reset: in_ready=%b out_valid=%b sum=%h", bus.in_ready, bus.out_valid, bus.sum);
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    accept(8'h0F, 8'h01, 0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_accept: in_ready never seen, required 1");
    end
    wait_valid(n);
    // Accepting cycle is cycle 0; out_valid is up in cycle 9, i.e. 8 edges
    // after the accepting edge.
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL basic_latency: edges=%0d required 8", n);
    end
    checks++;
    if (bus.sum !== 8'h10 || bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%h cout=%b ovf=%b required 10/0/0", bus.sum, bus.cout, bus.overflow);
    end
    retire();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_retire: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    $display("basic: 0F+01+0 -> sum=%h cout=%b ovf=%b latency=%0d", bus.sum, bus.cout, bus.overflow, n);
  endtask

  task automatic test_corners();
    int ta[2] = '{8'hFF, 8'h7F};
    int tb_[2] = '{8'h01, 8'h00};
    int tc[2] = '{0, 1};
    bit ok;
    int n;
    for (int k = 0; k < 2; k++) begin
      accept(ta[k], tb_[k], tc[k], ok);
      wait_valid(n);
      checks++;
      if (!ok || n < 0) begin
        errors++;
        $display("FAIL corner_hs: accept=%b wait=%0d required 1/>=0", ok, n);
      end
      checks++;
      if (bus.sum !== ref_sum(ta[k], tb_[k], tc[k]) || bus.cout !== ref_cout(ta[k], tb_[k], tc[k])
          || bus.overflow !== ref_ovf(ta[k], tb_[k], tc[k])) begin
        errors++;
        $display("FAIL corner_result: sum=%h cout=%b ovf=%b required %h/%b/%b", bus.sum, bus.cout,
                 bus.overflow, ref_sum(ta[k], tb_[k], tc[k]), ref_cout(ta[k], tb_[k], tc[k]),
                 ref_ovf(ta[k], tb_[k], tc[k]));
      end
      $display("corner: %h+%h+%0d -> sum=%h cout=%b ovf=%b", ta[k], tb_[k], tc[k], bus.sum, bus.cout, bus.overflow);
      retire();
    end
  endtask

  task automatic test_trace();
    int a = 8'h80, b = 8'h80, c = 0;
    int ai, bi, ci, m;
    bit ok;
    accept(a, b, c, ok);
    for (int i = 0; i < W; i++) begin
      m  = 1 << i;
      ai = (a >> i) & 1;
      bi = (b >> i) & 1;
      ci = ((a % m) + (b % m) + c) >> i;  // carry into bit i
      checks++;
      if (cell_p !== 1'(ai ^ bi) || cell_g !== 1'(ai & bi) || cell_cin !== 1'(ci)) begin
        errors++;
        $display("FAIL trace_bit%0d: pgc=%b%b%b required %0d%0d%0d", i, cell_p, cell_g, cell_cin,
                 ai ^ bi, ai & bi, ci);
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 8'h00 || bus.cout !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL trace_result: valid=%b sum=%h cout=%b ovf=%b required 1/00/1/1", bus.out_valid,
               bus.sum, bus.cout, bus.overflow);
    end
    checks++;
    if ({cell_p, cell_g, cell_cin} !== 3'b000) begin
      errors++;
      $display("FAIL trace_idle_cell: pgc=%b required 000", {cell_p, cell_g, cell_cin});
    end
    $display("trace: 80+80+0 -> sum=%h cout=%b ovf=%b", bus.sum, bus.cout, bus.overflow);
    retire();
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    int bad = 0;
    accept(8'h55, 8'h22, 1, ok);
    wait_valid(n);
    bus.op_a     = 8'hAA;
    bus.op_b     = 8'hCC;
    bus.op_cin   = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 8'h78
          || bus.cout !== 1'b0 || bus.overflow !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0 || n < 0) begin
      errors++;
      $display("FAIL stall_hold: bad_cycles=%0d wait=%0d sum=%h required 0 bad, sum 78", bad, n, bus.sum);
    end
    bus.in_valid = 1'b0;
    retire();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 8'h78) begin
      errors++;
      $display("FAIL stall_retire: out_valid=%b sum=%h required 0/78", bus.out_valid, bus.sum);
    end
    $display("backpressure: 55+22+1 held 20 cycles -> sum=%h bad=%0d", bus.sum, bad);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    accept(8'hA5, 8'h3C, 1, ok);
    tick();
    tick();
    tick();  // now presenting bit 3
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_a     = 8'h11;
    bus.op_b     = 8'h22;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 8'h00
        || {cell_p, cell_g, cell_cin} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_state: rdy=%b vld=%b sum=%h pgc=%b required 1/0/00/000", bus.in_ready,
               bus.out_valid, bus.sum, {cell_p, cell_g, cell_cin});
    end
    accept(8'h12, 8'h34, 0, ok);
    wait_valid(n);
    checks++;
    if (n !== 8 || bus.sum !== 8'h46 || bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next: lat=%0d sum=%h cout=%b ovf=%b required 8/46/0/0", n, bus.sum,
               bus.cout, bus.overflow);
    end
    $display("reset_mid: then 12+34+0 -> sum=%h", bus.sum);
    retire();
  endtask

  typedef struct {
    int a;
    int b;
    int c;
  } txn_t;

  task automatic test_back_to_back();
    txn_t q[$];
    txn_t t;
    int sent = 0, got = 0, bad = 0, cyc = 0;
    bit fire_in, fire_out;
    while ((sent < 1000 || q.size() != 0) && cyc < 60000) begin
      bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.op_a      = W'($urandom_range(0, 255));
      bus.op_b      = W'($urandom_range(0, 255));
      bus.op_cin    = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      // DUT outputs are stable until the coming edge, so these are the
      // handshakes that edge will complete.
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_dup: result %h with nothing outstanding", bus.sum);
        end else begin
          t = q.pop_front();
          got++;
          if (bus.sum !== ref_sum(t.a, t.b, t.c) || bus.cout !== ref_cout(t.a, t.b, t.c)
              || bus.overflow !== ref_ovf(t.a, t.b, t.c)) begin
            bad++;
            $display("FAIL b2b_result: %h+%h+%0d got %h/%b/%b required %h/%b/%b", t.a, t.b, t.c,
                     bus.sum, bus.cout, bus.overflow, ref_sum(t.a, t.b, t.c), ref_cout(t.a, t.b, t.c),
                     ref_ovf(t.a, t.b, t.c));
          end
        end
      end
      if (fire_in) begin
        t.a = int'(bus.op_a);
        t.b = int'(bus.op_b);
        t.c = int'(bus.op_cin);
        q.push_back(t);
        sent++;
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_compare: bad=%0d required 0", bad);
    end
    checks++;
    if (got !== 1000 || sent !== 1000) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d got=%0d required 1000/1000 (cycles=%0d)", sent, got, cyc);
    end
    $display("back_to_back: sent=%0d got=%0d cycles=%0d", sent, got, cyc);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_cin    = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_corners();
    test_trace();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
